cic_comb_sequencer: RTL

Decimation controller and time-shared comb stage for a bank of single-stage (N=1, M=1) CIC integrators that run on the RF clock.
- Counts RF sample strobes against a programmable decimation ratio and generates the decimation tick.
- Snapshots all channel integrators on the tick, then runs one shared 40-bit subtractor across channels serially.
- Emits scaled 16-bit audio samples over a valid/ready stream tagged with the channel number.
- Replaces the per-channel lr_clk comb registers with a single-clock sequenced comb.

---
 rtl/cic_comb_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cic_comb_sequencer.sv
// Decimation counter plus a time-shared comb stage for a bank of N=1, M=1 CIC integrators.
// Each accepted tick snapshots every integrator, then one subtractor walks the channels serially.
module cic_comb_sequencer #(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned SHIFT     = 11,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DEF_RATIO = 256
) (
    input  logic                                            rf_clk,
    input  logic                                            reset,
    input  logic                                            in_valid,
    input  logic [CHANNELS*ACC_W-1:0]                       int_bus,
    input  logic [CNT_W-1:0]                                cfg_ratio,
    input  logic                                            cfg_load,
    output logic [OUT_W-1:0]                                out_data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic                                            dec_tick,
    output logic                                            busy,
    output logic                                            overrun,
    input  logic                                            overrun_clr
);

    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2} state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   ratio;
    logic               primed;
    logic [CH_W-1:0]    ch;
    logic [ACC_W-1:0]   snap [CHANNELS];
    logic [ACC_W-1:0]   hist [CHANNELS];

    logic               load_ok;
    logic               tick_take;
    logic               last_ch;
    logic               prime_en;
    logic               snap_en;
    logic               emit_en;
    logic               accept_en;

    assign load_ok   = cfg_load && (state == IDLE) && (cfg_ratio != '0);
    assign tick_take = dec_tick && !load_ok;
    assign last_ch   = (ch == CH_W'(CHANNELS - 1));

    // Decimation counter; free-running regardless of FSM state or backpressure
    always_ff @(posedge rf_clk or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            ratio    <= CNT_W'(DEF_RATIO);
            dec_tick <= 1'b0;
        end else if (load_ok) begin
            ratio    <= cfg_ratio;
            count    <= '0;
            dec_tick <= 1'b0;
        end else begin
            dec_tick <= 1'b0;
            if (in_valid) begin
                if (count == ratio - CNT_W'(1)) begin
                    count    <= '0;
                    dec_tick <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge rf_clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick_take && primed) state_next = RUN;
            RUN:     state_next = WAIT;
            WAIT:    if (out_valid && out_ready) state_next = last_ch ? IDLE : RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prime_en  = 1'b0;
        snap_en   = 1'b0;
        emit_en   = 1'b0;
        accept_en = 1'b0;
        case (state)
            IDLE: begin
                if (tick_take) begin
                    prime_en = !primed;
                    snap_en  = primed;
                end
            end
            RUN:     emit_en   = 1'b1;
            WAIT:    accept_en = out_valid && out_ready;
            default: ;
        endcase
    end

    // Snapshot/history registers and the registered output stream
    always_ff @(posedge rf_clk or negedge reset) begin
        if (!reset) begin
            primed    <= 1'b0;
            ch        <= '0;
            out_data  <= '0;
            out_chan  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                snap[k] <= '0;
                hist[k] <= '0;
            end
        end else begin
            busy <= (state_next != IDLE);

            if (dec_tick && (state != IDLE)) overrun <= 1'b1;
            else if (overrun_clr)            overrun <= 1'b0;

            if (prime_en) begin
                primed <= 1'b1;
                for (int k = 0; k < CHANNELS; k++) hist[k] <= int_bus[k*ACC_W +: ACC_W];
            end else if (load_ok) begin
                primed <= 1'b0;
            end

            if (snap_en) begin
                ch <= '0;
                for (int k = 0; k < CHANNELS; k++) snap[k] <= int_bus[k*ACC_W +: ACC_W];
            end

            if (emit_en) begin
                out_data  <= OUT_W'((snap[ch] - hist[ch]) >> SHIFT);
                out_chan  <= ch;
                out_valid <= 1'b1;
            end

            if (accept_en) begin
                out_valid <= 1'b0;
                hist[ch]  <= snap[ch];
                if (!last_ch) ch <= ch + CH_W'(1);
            end
        end
    end

endmodule
